// File: rtl/proc_run_sequencer.sv
// proc_run_sequencer: command-driven Run controller for the multicycle core, with retire counting, PC trace FIFO and watchdog.
//  clk_i            system clock, rising edge
//  rst_ni           asynchronous active-low reset
//  cmd_valid_i      command present
//  cmd_ready_o      command accepted when valid & ready
//  cmd_op_i         00 STEP, 01 RUN_N, 10 RUN_FREE, 11 HALT
//  cmd_count_i      instruction budget for RUN_N
//  proc_run_o       registered core Run
//  proc_done_i      core Done pulse, one per retired instruction
//  proc_pc_i        core PC, sampled with proc_done_i
//  busy_o           high in RUN
//  retired_o        instructions retired since the last start
//  timeout_o        sticky watchdog fault
//  trace_valid_o    trace FIFO non-empty (show-ahead)
//  trace_pc_o       trace FIFO head, zero when empty
//  trace_ready_i    pop the head when valid & ready
//  trace_overflow_o sticky: a trace push was dropped
module proc_run_sequencer #(
    parameter int DATA_W      = 16,
    parameter int CNT_W       = 16,
    parameter int WDOG_CYCLES = 16,
    parameter int TRACE_DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [CNT_W-1:0]  cmd_count_i,
    output logic              proc_run_o,
    input  logic              proc_done_i,
    input  logic [DATA_W-1:0] proc_pc_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  retired_o,
    output logic              timeout_o,
    output logic              trace_valid_o,
    output logic [DATA_W-1:0] trace_pc_o,
    input  logic              trace_ready_i,
    output logic              trace_overflow_o
);
    localparam int AW = $clog2(TRACE_DEPTH);
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [1:0] OP_STEP = 2'd0, OP_RUN_N = 2'd1, OP_RUN_FREE = 2'd2, OP_HALT = 2'd3;
    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
    state_t            state_q, state_d;
    logic              run_q, free_q, free_d, halt_q, halt_d, to_q, to_d, ovf_q, ovf_d;
    logic              halt_now, push, pop, full, empty, push_ok;
    logic [CNT_W-1:0]  rem_q, rem_d, ret_q, ret_d;
    logic [WW-1:0]     wdog_q, wdog_d;
    logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
    logic [DATA_W-1:0] mem_q [TRACE_DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty            = wr_q == rd_q;
    assign full             = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop              = !empty && trace_ready_i;
    assign push_ok          = push && (!full || pop);
    assign proc_run_o       = run_q;
    assign busy_o           = state_q == RUN;
    assign retired_o        = ret_q;
    assign timeout_o        = to_q;
    assign trace_overflow_o = ovf_q;
    assign trace_valid_o    = !empty;
    assign trace_pc_o       = empty ? '0 : mem_q[rd_q[AW-1:0]];
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        free_d      = free_q;
        halt_d      = halt_q;
        wdog_d      = wdog_q;
        ret_d       = ret_q;
        to_d        = to_q;
        ovf_d       = ovf_q;
        cmd_ready_o = 1'b1;
        halt_now    = 1'b0;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                // A zero-budget RUN_N and HALT are accepted without starting.
                if (cmd_valid_i && cmd_op_i != OP_HALT && !(cmd_op_i == OP_RUN_N && cmd_count_i == '0)) begin
                    state_d = RUN;
                    rem_d   = (cmd_op_i == OP_STEP) ? CNT_W'(1) : cmd_count_i;
                    free_d  = cmd_op_i == OP_RUN_FREE;
                    halt_d  = 1'b0;
                    wdog_d  = '0;
                    ret_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                cmd_ready_o = cmd_op_i == OP_HALT;
                halt_now    = halt_q || (cmd_valid_i && cmd_ready_o);
                halt_d      = halt_now;
                if (proc_done_i) begin
                    push   = 1'b1;
                    ret_d  = ret_q + CNT_W'(1);
                    rem_d  = rem_q - CNT_W'(1);
                    wdog_d = '0;
                    // Leave on the retiring edge so Run is low before the next fetch.
                    if (halt_now || (!free_q && rem_q == CNT_W'(1))) state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                    if (wdog_d == WW'(WDOG_CYCLES)) begin
                        state_d = FAULT;
                        to_d    = 1'b1;
                    end
                end
            end
            FAULT: begin
                if (cmd_valid_i && cmd_op_i == OP_HALT) begin
                    state_d = IDLE;
                    to_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (push && full && !pop) ovf_d = 1'b1;
        wr_d = push_ok ? wr_q + (AW+1)'(1) : wr_q;
        rd_d = pop ? rd_q + (AW+1)'(1) : rd_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
            rem_q   <= '0;
            free_q  <= 1'b0;
            halt_q  <= 1'b0;
            wdog_q  <= '0;
            ret_q   <= '0;
            to_q    <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= state_d == RUN;
            rem_q   <= rem_d;
            free_q  <= free_d;
            halt_q  <= halt_d;
            wdog_q  <= wdog_d;
            ret_q   <= ret_d;
            to_q    <= to_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= proc_pc_i;
    end
endmodule

// File: tb/tb_proc_run_sequencer.sv
// tb_proc_run_sequencer: table vectors, directed corner sequences and a randomized run against a queue-based reference model.
module tb_proc_run_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, proc_run, proc_done, busy, timeout, trace_valid, trace_ready, trace_overflow;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_count, proc_pc, retired, trace_pc;
    int          checks = 0, errors = 0;

    proc_run_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_count_i(cmd_count), .proc_run_o(proc_run), .proc_done_i(proc_done),
        .proc_pc_i(proc_pc), .busy_o(busy), .retired_o(retired), .timeout_o(timeout),
        .trace_valid_o(trace_valid), .trace_pc_o(trace_pc), .trace_ready_i(trace_ready),
        .trace_overflow_o(trace_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic v; logic [1:0] op; logic [15:0] cnt; logic d; logic [15:0] pc; logic tr;
        logic rdy; logic run; logic [15:0] ret; logic tv; logic [15:0] tpc;
    } vec_t;
    vec_t tbl[$];

    // Reference model state: mode 0 idle, 1 running, 2 faulted.
    int          m_st, m_rem, m_wd, m_ret;
    bit          m_free, m_halt, m_to, m_ovf;
    logic [15:0] m_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_in();
        cmd_valid = 0; cmd_op = 0; cmd_count = 0; proc_done = 0; proc_pc = 0; trace_ready = 0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic add(input logic v, input logic [1:0] op, input logic [15:0] cnt, input logic d,
                       input logic [15:0] pc, input logic tr, input logic rdy, input logic run,
                       input logic [15:0] ret, input logic tv, input logic [15:0] tpc);
        vec_t e;
        e.v = v; e.op = op; e.cnt = cnt; e.d = d; e.pc = pc; e.tr = tr;
        e.rdy = rdy; e.run = run; e.ret = ret; e.tv = tv; e.tpc = tpc;
        tbl.push_back(e);
    endtask

    task automatic m_start(input int rem, input bit free);
        m_st = 1; m_rem = rem; m_free = free; m_halt = 0; m_wd = 0; m_ret = 0; m_ovf = 0;
    endtask

    function automatic bit m_ready();
        return m_st != 1 || cmd_op == 2'd3;
    endfunction

    task automatic m_compare();
        chk("m_ready", cmd_ready, m_ready());
        chk("m_run", proc_run, m_st == 1);
        chk("m_busy", busy, m_st == 1);
        chk("m_retired", retired, 16'(m_ret));
        chk("m_timeout", timeout, m_to);
        chk("m_tvalid", trace_valid, m_q.size() > 0);
        chk("m_tpc", trace_pc, m_q.size() > 0 ? m_q[0] : 16'h0);
        chk("m_ovf", trace_overflow, m_ovf);
    endtask

    task automatic m_step();
        bit acc, pop, pushing, hp;
        acc = cmd_valid && m_ready();
        pop = m_q.size() > 0 && trace_ready;
        pushing = 0;
        if (m_st == 0 && acc) begin
            if (cmd_op == 2'd0) m_start(1, 0);
            else if (cmd_op == 2'd1 && cmd_count != 0) m_start(int'(cmd_count), 0);
            else if (cmd_op == 2'd2) m_start(0, 1);
        end else if (m_st == 1) begin
            hp = m_halt || acc;
            m_halt = hp;
            if (proc_done) begin
                pushing = 1;
                m_ret++;
                m_rem--;
                m_wd = 0;
                if (hp || (!m_free && m_rem == 0)) m_st = 0;
            end else begin
                m_wd++;
                if (m_wd >= 16) begin
                    m_st = 2;
                    m_to = 1;
                end
            end
        end else if (m_st == 2 && acc && cmd_op == 2'd3) begin
            m_st = 0;
            m_to = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (pushing) begin
            if (m_q.size() < 8) m_q.push_back(proc_pc);
            else m_ovf = 1;
        end
    endtask

    initial begin
        int prob;
        do_reset();
        // STEP, RUN_N 3 with pops, Done outside RUN, zero-budget RUN_N, idle HALT.
        add(0,0,0,0,16'h00,0, 1,0,0,0,16'h00);
        add(1,0,0,0,16'h00,0, 1,0,0,0,16'h00);
        add(0,0,0,0,16'h00,0, 0,1,0,0,16'h00);
        add(0,0,0,0,16'h00,0, 0,1,0,0,16'h00);
        add(0,0,0,0,16'h00,0, 0,1,0,0,16'h00);
        add(0,0,0,1,16'h00,0, 0,1,0,0,16'h00);
        add(0,0,0,0,16'h00,0, 1,0,1,1,16'h00);
        add(0,0,0,0,16'h00,1, 1,0,1,1,16'h00);
        add(0,0,0,0,16'h00,0, 1,0,1,0,16'h00);
        add(1,1,3,0,16'h00,0, 1,0,1,0,16'h00);
        add(0,0,0,1,16'h10,0, 0,1,0,0,16'h00);
        add(0,0,0,1,16'h11,0, 0,1,1,1,16'h10);
        add(0,0,0,0,16'h00,0, 0,1,2,1,16'h10);
        add(0,0,0,1,16'h12,0, 0,1,2,1,16'h10);
        add(0,0,0,0,16'h00,1, 1,0,3,1,16'h10);
        add(0,0,0,0,16'h00,1, 1,0,3,1,16'h11);
        add(0,0,0,0,16'h00,1, 1,0,3,1,16'h12);
        add(0,0,0,0,16'h00,0, 1,0,3,0,16'h00);
        add(0,0,0,1,16'h99,0, 1,0,3,0,16'h00);
        add(1,1,0,0,16'h00,0, 1,0,3,0,16'h00);
        add(0,0,0,0,16'h00,0, 1,0,3,0,16'h00);
        add(1,3,0,0,16'h00,0, 1,0,3,0,16'h00);
        add(0,0,0,0,16'h00,0, 1,0,3,0,16'h00);
        foreach (tbl[i]) begin
            cmd_valid = tbl[i].v; cmd_op = tbl[i].op; cmd_count = tbl[i].cnt;
            proc_done = tbl[i].d; proc_pc = tbl[i].pc; trace_ready = tbl[i].tr;
            #1;
            chk($sformatf("tbl%0d_ready", i), cmd_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_run", i), proc_run, tbl[i].run);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].run);
            chk($sformatf("tbl%0d_retired", i), retired, tbl[i].ret);
            chk($sformatf("tbl%0d_tvalid", i), trace_valid, tbl[i].tv);
            chk($sformatf("tbl%0d_tpc", i), trace_pc, tbl[i].tpc);
            tick();
        end

        // Watchdog: 16 Done-less RUN cycles fault; FAULT ignores non-HALT, HALT recovers.
        do_reset();
        cmd_valid = 1; cmd_op = 2'd2;
        tick();
        cmd_valid = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("wdog_run%0d", i), proc_run, 1);
            chk($sformatf("wdog_to%0d", i), timeout, 0);
            tick();
        end
        #1;
        chk("wdog_fault_run", proc_run, 0);
        chk("wdog_fault_to", timeout, 1);
        chk("wdog_fault_busy", busy, 0);
        cmd_valid = 1; cmd_op = 2'd1; cmd_count = 5;
        #1 chk("fault_ready", cmd_ready, 1);
        tick();
        #1;
        chk("fault_ignore_to", timeout, 1);
        chk("fault_ignore_run", proc_run, 0);
        cmd_op = 2'd3;
        tick();
        cmd_valid = 0;
        #1;
        chk("fault_halt_to", timeout, 0);
        chk("fault_halt_run", proc_run, 0);
        cmd_valid = 1; cmd_op = 2'd0;
        tick();
        cmd_valid = 0;
        #1 chk("after_fault_step_run", proc_run, 1);

        // Overflow: RUN_N 10 without pops keeps pc 0..7.
        do_reset();
        cmd_valid = 1; cmd_op = 2'd1; cmd_count = 10;
        tick();
        cmd_valid = 0;
        for (int i = 0; i < 10; i++) begin
            proc_done = 1; proc_pc = 16'(i);
            tick();
        end
        proc_done = 0;
        #1;
        chk("ovf_run", proc_run, 0);
        chk("ovf_retired", retired, 10);
        chk("ovf_flag", trace_overflow, 1);
        for (int i = 0; i < 8; i++) begin
            #1 chk($sformatf("ovf_pop%0d", i), trace_pc, i);
            trace_ready = 1;
            tick();
            trace_ready = 0;
        end
        #1 chk("ovf_drained", trace_valid, 0);
        // Full FIFO with simultaneous push and pop: both happen, no overflow.
        cmd_valid = 1; cmd_op = 2'd1; cmd_count = 9;
        tick();
        cmd_valid = 0;
        for (int i = 0; i < 9; i++) begin
            proc_done = 1; proc_pc = 16'(16'h40 + i); trace_ready = (i == 8);
            tick();
        end
        proc_done = 0; trace_ready = 0;
        #1;
        chk("fullpp_ovf", trace_overflow, 0);
        chk("fullpp_retired", retired, 9);
        chk("fullpp_head", trace_pc, 16'h41);

        // HALT mid-instruction: stall non-HALT, one more Done counted, then stop.
        do_reset();
        cmd_valid = 1; cmd_op = 2'd2;
        tick();
        cmd_valid = 0; proc_done = 1; proc_pc = 16'h20;
        tick();
        proc_done = 0; cmd_valid = 1; cmd_op = 2'd0;
        #1 chk("run_stall_ready", cmd_ready, 0);
        tick();
        cmd_op = 2'd3;
        #1 chk("run_halt_ready", cmd_ready, 1);
        tick();
        cmd_valid = 0;
        tick();
        #1 chk("halt_pending_run", proc_run, 1);
        proc_done = 1; proc_pc = 16'h21;
        tick();
        proc_done = 0;
        #1;
        chk("halt_exit_run", proc_run, 0);
        chk("halt_exit_busy", busy, 0);
        chk("halt_exit_retired", retired, 2);
        proc_done = 1;
        tick();
        proc_done = 0;
        #1 chk("idle_done_ignored", retired, 2);
        // HALT accepted together with Done.
        cmd_valid = 1; cmd_op = 2'd2;
        tick();
        cmd_op = 2'd3; proc_done = 1; proc_pc = 16'h30;
        tick();
        cmd_valid = 0; proc_done = 0;
        #1;
        chk("halt_done_run", proc_run, 0);
        chk("halt_done_retired", retired, 1);
        // Asynchronous reset mid-RUN.
        cmd_valid = 1; cmd_op = 2'd2;
        tick();
        cmd_valid = 0; proc_done = 1;
        tick();
        proc_done = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_run", proc_run, 0);
        chk("arst_busy", busy, 0);
        chk("arst_retired", retired, 0);
        chk("arst_tvalid", trace_valid, 0);
        chk("arst_tpc", trace_pc, 0);
        chk("arst_to", timeout, 0);
        chk("arst_ovf", trace_overflow, 0);
        @(negedge clk);
        rst_n = 1;

        // Randomized traffic against the reference model.
        do_reset();
        m_st = 0; m_rem = 0; m_wd = 0; m_ret = 0; m_free = 0; m_halt = 0; m_to = 0; m_ovf = 0;
        m_q.delete();
        prob = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) begin
                case ($urandom % 4)
                    0: prob = 0;
                    1: prob = 20;
                    2: prob = 50;
                    default: prob = 90;
                endcase
            end
            cmd_valid = ($urandom % 4) == 0;
            cmd_op = 2'($urandom);
            cmd_count = ($urandom % 8 == 0) ? 16'($urandom) : 16'($urandom % 6);
            proc_done = int'($urandom % 100) < prob;
            proc_pc = 16'($urandom);
            trace_ready = $urandom % 2;
            #1;
            m_compare();
            m_step();
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
